// File: rtl/butterfly_pkg.sv
// rtl/butterfly_pkg.sv - shared types and constants for the butterfly operand host
// Contents: host state enum, step constants, byte width, packed operand set and
// a helper that selects the byte to present for a given step.
package butterfly_pkg;

    localparam int BYTE_W = 8;

    typedef logic [3:0] step_t;

    localparam step_t STEP_LAST_LOAD  = 4'd5;
    localparam step_t STEP_FIRST_DISP = 4'd6;
    localparam step_t STEP_CLEAR      = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        RELEASE,
        DONE
    } host_state_t;

    // Index 0 is ReW, then ImW, ReB, ImB, ReA, ImA: the order they are pressed in.
    typedef logic [5:0][BYTE_W-1:0] operand_set_t;

    // Load steps present their operand; display and clear steps present zero.
    function automatic logic [BYTE_W-1:0] step_byte(input operand_set_t ops, input step_t step);
        logic [BYTE_W-1:0] b;
        b = '0;
        if (step <= STEP_LAST_LOAD) begin
            b = ops[step[2:0]];
        end
        return b;
    endfunction

endpackage

// File: rtl/butterfly_host_hold_timer.sv
// rtl/butterfly_host_hold_timer.sv - loadable down-counter timing one press or release phase
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        reload the counter with HOLD_CYCLES-1
//   tc          terminal count: high while the counter sits at zero
module hold_timer #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tc
);

    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    // Loading on the state-change edge makes the phase last exactly
    // HOLD_CYCLES cycles: HOLD_CYCLES-1 down to 0, leaving on tc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/butterfly_host.sv
// rtl/butterfly_host.sv - operand sequencer and result collector for the serial FFT butterfly
// Ports:
//   Clock, nReset             clock and asynchronous active-low reset
//   start                     one-cycle run request, ignored unless idle
//   opReW..opImA              operand set, latched on an accepted start
//   dataOut, ReadyOut         operand byte and press strobe toward the butterfly
//   resultIn                  butterfly result bus
//   ReY, ImY, ReZ, ImZ        captured results
//   busy, done                transaction in progress / one-cycle completion pulse
module butterfly_host
    import butterfly_pkg::*;
#(
    parameter int HOLD_CYCLES = 16
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              start,
    input  logic [BYTE_W-1:0] opReW,
    input  logic [BYTE_W-1:0] opImW,
    input  logic [BYTE_W-1:0] opReB,
    input  logic [BYTE_W-1:0] opImB,
    input  logic [BYTE_W-1:0] opReA,
    input  logic [BYTE_W-1:0] opImA,
    output logic [BYTE_W-1:0] dataOut,
    output logic              ReadyOut,
    input  logic [BYTE_W-1:0] resultIn,
    output logic [BYTE_W-1:0] ReY,
    output logic [BYTE_W-1:0] ImY,
    output logic [BYTE_W-1:0] ReZ,
    output logic [BYTE_W-1:0] ImZ,
    output logic              busy,
    output logic              done
);

    localparam step_t STEP_IMY = 4'd7;
    localparam step_t STEP_REZ = 4'd8;

    host_state_t       state;
    host_state_t       state_nxt;
    step_t             step;
    step_t             step_nxt;
    operand_set_t      ops;
    logic [BYTE_W-1:0] data_nxt;
    logic              tc;
    logic              timer_load;
    logic              accept;
    logic              ready_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              capture_en;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (Clock),
        .rst_n(nReset),
        .load (timer_load),
        .tc   (tc)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PRESS;
            PRESS:   if (tc) state_nxt = RELEASE;
            RELEASE: if (tc) state_nxt = (step == STEP_CLEAR) ? DONE : PRESS;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept     = 1'b0;
        step_nxt   = step;
        data_nxt   = dataOut;
        busy_nxt   = busy;
        capture_en = 1'b0;
        // Every entry into PRESS or RELEASE restarts the phase timer.
        timer_load = (state_nxt != state) && ((state_nxt == PRESS) || (state_nxt == RELEASE));
        // Registered strobe computed from the next state, so it is high exactly in PRESS.
        ready_nxt  = (state_nxt == PRESS);
        done_nxt   = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    step_nxt = '0;
                    data_nxt = opReW;
                    busy_nxt = 1'b1;
                end
            end
            RELEASE: begin
                if (tc) begin
                    // Last release cycle: the butterfly is still showing this step's result.
                    capture_en = (step >= STEP_FIRST_DISP) && (step < STEP_CLEAR);
                    if (step != STEP_CLEAR) begin
                        step_nxt = step_t'(step + 4'd1);
                        data_nxt = step_byte(ops, step_nxt);
                    end
                end
            end
            DONE: begin
                busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            step     <= '0;
            ops      <= '0;
            dataOut  <= '0;
            ReadyOut <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ReY      <= '0;
            ImY      <= '0;
            ReZ      <= '0;
            ImZ      <= '0;
        end else begin
            step     <= step_nxt;
            dataOut  <= data_nxt;
            ReadyOut <= ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            if (accept) begin
                ops <= {opImA, opReA, opImB, opReB, opImW, opReW};
            end
            if (capture_en) begin
                case (step)
                    STEP_FIRST_DISP: ReY <= resultIn;
                    STEP_IMY:        ImY <= resultIn;
                    STEP_REZ:        ReZ <= resultIn;
                    default:         ImZ <= resultIn;
                endcase
            end
        end
    end

endmodule

// File: doc/butterfly_host.md
# butterfly_host

Operand sequencer and result collector driving the serial operand/display interface of the FFT butterfly. It accepts one complete operand set (W, B, A, each complex 8-bit) in parallel on a start pulse. It presents the operands one at a time on an 8-bit bus with a timed ReadyIn-style press/release strobe. It then steps the butterfly through its four display phases, captures ReY, ImY, ReZ and ImZ from the result bus, and finally issues a clear press.

## Interface
- HOLD_CYCLES, default 16: cycles the strobe is held high, and then held low, per press; must exceed the butterfly debouncer settle time; minimum 2.
- Clock  input  1  system clock, all logic on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run a full transaction; ignored while busy.
- opReW, opImW, opReB, opImB, opReA, opImA  input  8 each  operand set, sampled on accepted start.
- dataOut  output  8  operand byte to the butterfly dataIn.
- ReadyOut  output  1  press strobe to the butterfly ReadyIn.
- resultIn  input  8  butterfly result bus.
- ReY, ImY, ReZ, ImZ  output  8 each  captured results, held until next capture or reset.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the transaction completes.

## Operation
- Fixed 11-step press sequence, step index 0..10:
  - Steps 0-5: load ReW, ImW, ReB, ImB, ReA, ImA in that order; dataOut = operand of the step.
  - Steps 6-9: display ReY, ImY, ReZ, ImZ; dataOut = 0.
  - Step 10: clear; dataOut = 0.
- States:
  - IDLE -> PRESS on start. In the same edge, latch all six operands and set step = 0.
  - PRESS -> RELEASE after HOLD_CYCLES cycles.
  - RELEASE -> PRESS (next step), or DONE after step 10, once HOLD_CYCLES cycles elapse.
  - DONE -> IDLE after one cycle.
- Capture: on the last RELEASE cycle of steps 6-9, resultIn is registered into ReY/ImY/ReZ/ImZ respectively. No capture on other steps.
- Operands are latched on start. Input changes during busy have no effect.
- start while busy, or in the DONE cycle, is dropped; no queuing.
- Values are passed through unchanged. The block does no arithmetic, and signedness is irrelevant to it.

## Timing
- Reset values: dataOut = 0, ReadyOut = 0, busy = 0, done = 0, all result outputs = 0, state IDLE, step = 0, timer = 0.
- ReadyOut is registered and is 1 exactly in PRESS. Every press is exactly HOLD_CYCLES high followed by HOLD_CYCLES low, with no glitches.
- dataOut is registered and holds a step's value stable from the first PRESS cycle through the last RELEASE cycle of that step.
- busy rises the cycle after start is sampled. Transaction length from the start edge to the done pulse is 22*HOLD_CYCLES + 1 cycles. done and busy-fall occur on the same edge.
- Asynchronous reset mid-transaction takes effect immediately:
  - ReadyOut falls immediately.
  - Partially captured results revert to 0.
  - Nothing resumes after reset release; a new start is required.
- Timer counts 0..HOLD_CYCLES-1 and wraps on each state change. The step counter never exceeds 10.

## Structure
- Package butterfly_pkg:
  - host state enum (IDLE, PRESS, RELEASE, DONE).
  - step constants STEP_LAST_LOAD = 5, STEP_FIRST_DISP = 6, STEP_CLEAR = 10.
  - byte width constant = 8.
- Sub-module hold_timer: loadable down-counter with HOLD_CYCLES parameter and a terminal-count output, reused by PRESS and RELEASE.
- Top contains the FSM, step counter, operand array, and capture registers.

## Test plan
All scenarios use HOLD_CYCLES = 4.
- Operands 0x01,0x02,0x03,0x04,0x05,0x06, start -> dataOut sequence 01,02,03,04,05,06,00×5; each strobe is 4 high / 4 low; done 89 cycles after the start edge.
- Bench model drives resultIn = 0x11, 0x22, 0x33, 0x44 during display steps 6..9 -> ReY = 0x11, ImY = 0x22, ReZ = 0x33, ImZ = 0x44 at done; values remain stable afterwards.
- start re-pulsed at step 3 and operands changed mid-run -> sequence and timing are unchanged and the original operands are sent.
- nReset asserted during step 7 PRESS -> ReadyOut = 0 and all outputs = 0 immediately; after release, the block stays idle until the next start.
- Back-to-back transactions: start the cycle after done -> accepted; the second run produces new results and correct cycle counts.
- start during the DONE cycle -> ignored; busy stays 0.
